// File: rtl/fpmul_host_if_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpmul_host_if_if
//  Description : Host register bus and multiplier handshake bundle for
//                fpmul_host_if.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpmul_host_if_if;
    logic        WE;
    logic [1:0]  Addr;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        Irq;
    logic        FStart;
    logic [31:0] FA;
    logic [31:0] FB;
    logic        FDone;
    logic [31:0] FP;
    logic        FOF;
    logic        FUF;
    logic        FNaNF;
    logic        FInfF;
    logic        FDNF;
    logic        FZF;

    modport slave (
        input  WE, Addr, WD, FDone, FP, FOF, FUF, FNaNF, FInfF, FDNF, FZF,
        output RD, Irq, FStart, FA, FB
    );

    modport master (
        output WE, Addr, WD, FDone, FP, FOF, FUF, FNaNF, FInfF, FDNF, FZF,
        input  RD, Irq, FStart, FA, FB
    );
endinterface
`default_nettype wire

// File: rtl/fpmul_host_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpmul_host_if
//  Description : Host register front end for a floating-point multiplier:
//                operand/result registers, start handshake, completion timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpmul_host_if #(
    parameter int TIMEOUT = 32
) (
    input wire              Clk,
    input wire              Rst,
    fpmul_host_if_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] c_ADDR_OPA  = 2'd0;
    localparam logic [1:0] c_ADDR_OPB  = 2'd1;
    localparam logic [1:0] c_ADDR_CTRL = 2'd2;
    localparam logic [4:0] c_TO_LAST   = 5'(TIMEOUT - 1);

    state_t      r_state,    w_state_nxt;
    logic        r_req_cnt,  w_req_cnt_nxt;
    logic [4:0]  r_wait_cnt, w_wait_cnt_nxt;
    logic [31:0] r_opa,      w_opa_nxt;
    logic [31:0] r_opb,      w_opb_nxt;
    logic [31:0] r_result,   w_result_nxt;
    logic        r_valid,    w_valid_nxt;
    logic        r_toerr,    w_toerr_nxt;
    logic [5:0]  r_flags,    w_flags_nxt;

    logic        w_busy;
    logic        w_ctrl_wr;
    logic        w_go;
    logic        w_clr;
    logic [31:0] w_status;

    assign w_busy    = (r_state != S_IDLE);
    assign w_ctrl_wr = bus.WE && (bus.Addr == c_ADDR_CTRL);
    assign w_go      = w_ctrl_wr && bus.WD[0];
    assign w_clr     = w_ctrl_wr && bus.WD[1];
    assign w_status  = {23'd0, r_flags, r_toerr, r_valid, w_busy};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= S_IDLE;
            r_req_cnt  <= 1'b0;
            r_wait_cnt <= 5'd0;
            r_opa      <= 32'd0;
            r_opb      <= 32'd0;
            r_result   <= 32'd0;
            r_valid    <= 1'b0;
            r_toerr    <= 1'b0;
            r_flags    <= 6'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_cnt  <= w_req_cnt_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_opa      <= w_opa_nxt;
            r_opb      <= w_opb_nxt;
            r_result   <= w_result_nxt;
            r_valid    <= w_valid_nxt;
            r_toerr    <= w_toerr_nxt;
            r_flags    <= w_flags_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_req_cnt_nxt  = r_req_cnt;
        w_wait_cnt_nxt = r_wait_cnt;
        w_opa_nxt      = r_opa;
        w_opb_nxt      = r_opb;
        w_result_nxt   = r_result;
        w_valid_nxt    = r_valid;
        w_toerr_nxt    = r_toerr;
        w_flags_nxt    = r_flags;

        // Operands are frozen while busy so FA/FB hold for the whole operation.
        if (bus.WE && !w_busy && (bus.Addr == c_ADDR_OPA)) begin
            w_opa_nxt = bus.WD;
        end
        if (bus.WE && !w_busy && (bus.Addr == c_ADDR_OPB)) begin
            w_opb_nxt = bus.WD;
        end

        if (w_clr) begin
            w_valid_nxt = 1'b0;
            w_toerr_nxt = 1'b0;
            w_flags_nxt = 6'd0;
        end

        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_valid_nxt   = 1'b0;
                    w_toerr_nxt   = 1'b0;
                    w_req_cnt_nxt = 1'b0;
                    w_state_nxt   = S_REQ;
                end
            end
            S_REQ: begin
                if (r_req_cnt) begin
                    w_req_cnt_nxt  = 1'b0;
                    w_wait_cnt_nxt = 5'd0;
                    w_state_nxt    = S_WAIT;
                end else begin
                    w_req_cnt_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                // Completion wins over a timeout landing on the same edge.
                if (bus.FDone) begin
                    w_result_nxt   = bus.FP;
                    w_flags_nxt    = {bus.FOF, bus.FUF, bus.FNaNF,
                                      bus.FInfF, bus.FDNF, bus.FZF};
                    w_valid_nxt    = 1'b1;
                    w_wait_cnt_nxt = 5'd0;
                    w_state_nxt    = S_IDLE;
                end else if (r_wait_cnt == c_TO_LAST) begin
                    w_toerr_nxt    = 1'b1;
                    w_wait_cnt_nxt = 5'd0;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 5'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.FStart = (r_state == S_REQ);
    assign bus.FA     = r_opa;
    assign bus.FB     = r_opb;
    assign bus.Irq    = r_valid;

    always_comb begin
        case (bus.Addr)
            c_ADDR_OPA:  bus.RD = r_opa;
            c_ADDR_OPB:  bus.RD = r_opb;
            c_ADDR_CTRL: bus.RD = w_status;
            default:     bus.RD = r_result;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/fpmul_host_if.md
FPMUL_HOST_IF -- requirements
Module: fpmul_host_if

Interface
REQ-001 Parameter TIMEOUT, default 32, SHALL be the maximum WAIT-state cycles allowed before FDone is declared missing.
REQ-002 Clk  in  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-003 Rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-004 WE  in  1  SHALL be the host write strobe.
REQ-005 Addr  in  2  SHALL be the register select: 0 OPA, 1 OPB, 2 CTRL/STATUS, 3 RESULT.
REQ-006 WD  in  32  SHALL be the host write data.
REQ-007 RD  out  32  SHALL be the combinational read data for Addr.
REQ-008 Irq  out  1  SHALL equal the VALID bit.
REQ-009 FStart  out  1  SHALL be the start request to the multiplier.
REQ-010 FA, FB  out  32 each  SHALL be the operands to the multiplier, driven from OPA and OPB.
REQ-011 FDone  in  1  SHALL be the multiplier completion pulse.
REQ-012 FP  in  32  SHALL be the multiplier product.
REQ-013 FOF, FUF, FNaNF, FInfF, FDNF, FZF  in  1 each  SHALL be the multiplier flags.

Function
REQ-014 Register map:
- OPA and OPB are read/write.
- RESULT is read-only; writes to it are ignored.
- CTRL write: WD[0] = GO, WD[1] = CLR.
- STATUS read: bit0 BUSY, bit1 VALID, bit2 TOERR, bits[8:3] = {OF,UF,NaNF,InfF,DNF,ZF}, all other bits 0.
REQ-015 The FSM SHALL have states IDLE, REQ and WAIT; BUSY = 1 in REQ and WAIT.
REQ-016 In IDLE, a CTRL write with GO = 1 SHALL clear VALID and TOERR and move to REQ on that edge.
REQ-017 FStart SHALL be 1 only in REQ, for exactly 2 consecutive cycles, then the FSM SHALL move to WAIT.
- Two cycles guarantee capture whether the multiplier is in its post-done reset cycle or its wait-for-start cycle.
REQ-018 In WAIT, a 5-bit cycle counter SHALL increment each cycle, starting from 0 on entry.
REQ-019 In WAIT with FDone = 1 on an edge, the block SHALL, on that edge:
- latch FP into RESULT;
- latch the six flags into STATUS[8:3];
- set VALID = 1;
- return to IDLE.
REQ-020 In WAIT, if the counter reaches TIMEOUT-1 with FDone = 0, the block SHALL set TOERR = 1, leave RESULT and the flags unchanged, and return to IDLE.
REQ-021 FDone = 1 on the same edge the counter reaches TIMEOUT-1 SHALL be treated as completion; TOERR stays 0.
REQ-022 FDone SHALL be ignored in IDLE and REQ.
REQ-023 Writes to OPA or OPB while BUSY SHALL be ignored, so FA and FB stay stable from REQ entry through completion.
REQ-024 GO while BUSY SHALL be ignored.
REQ-025 CLR SHALL clear VALID, TOERR and STATUS[8:3] in any state.
- When GO and CLR are written together in IDLE, the clear applies and REQ is entered.
- CLR has no effect on the FSM state.
REQ-026 A CTRL write with both GO and CLR at 0 SHALL have no effect.
REQ-027 RD SHALL reflect register updates from the cycle after the updating edge.
REQ-028 Read latency: zero cycles, with no read side effects.

Reset
REQ-029 Rst SHALL asynchronously force:
- state IDLE and counter 0;
- OPA, OPB and RESULT to 0;
- VALID, TOERR and all six flag bits to 0;
- FStart, Irq and BUSY to 0.
REQ-030 Rst asserted mid-operation SHALL abandon the operation; a late FDone after reset release SHALL be ignored per REQ-022.

Verification
REQ-031 The bench SHALL cover these scenarios:
- Multiply: write OPA = 0x40000000, OPB = 0x40400000, GO; connect the real FPMUL. Required: FStart high exactly 2 cycles, RESULT = 0x40C00000, STATUS = 0x002, Irq = 1.
- Timeout: stub FDone tied to 0, then GO. Required: TOERR set 32 cycles after WAIT entry, STATUS = 0x004, RESULT unchanged.
- Ignored while busy: GO, then in WAIT write OPA = 0xFFFFFFFF and GO again. Required: FA unchanged, one FStart burst only, result still correct.
- Flag capture: OPA = 0x7F800000, OPB = 0x00000000 (inf*0) with the real FPMUL. Required: NaNF bit (STATUS[6]) = 1, VALID = 1.
- CLR and abort: CLR after completion gives STATUS = 0x000; Rst asserted in WAIT gives BUSY = 0, FStart = 0, RESULT = 0, and a stub FDone pulse 3 cycles later leaves VALID = 0.
